// File: rtl/home_auto_pkg.sv
// Shared home-automation definitions: source indices, display codes,
// scheduler FSM encoding, default temperature thresholds and small helpers.
package home_auto_pkg;

  localparam int NUM_SRC = 6;

  // Event source indices (bit positions in the event/pending vectors)
  localparam logic [2:0] SRC_FD     = 3'd0;
  localparam logic [2:0] SRC_RD     = 3'd1;
  localparam logic [2:0] SRC_FA     = 3'd2;
  localparam logic [2:0] SRC_W      = 3'd3;
  localparam logic [2:0] SRC_HEATER = 3'd4;
  localparam logic [2:0] SRC_COOLER = 3'd5;

  // Display codes: 0 is idle, otherwise source index + 1
  localparam logic [2:0] DISP_IDLE   = 3'd0;
  localparam logic [2:0] DISP_FD     = 3'd1;
  localparam logic [2:0] DISP_RD     = 3'd2;
  localparam logic [2:0] DISP_FA     = 3'd3;
  localparam logic [2:0] DISP_W      = 3'd4;
  localparam logic [2:0] DISP_HEATER = 3'd5;
  localparam logic [2:0] DISP_COOLER = 3'd6;

  // Default temperature thresholds (strict comparisons)
  localparam int DEF_LOW_T  = 10;
  localparam int DEF_HIGH_T = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DWELL = 2'd2
  } sched_state_t;

  // Source index to display/actuator code
  function automatic logic [2:0] disp_code(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

  // Source index to one-hot source vector
  function automatic logic [5:0] src_onehot(input logic [2:0] idx);
    return 6'b000001 << idx;
  endfunction

  // Next index in the 0..5 rotation; out-of-range values fold to 0
  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return (p >= SRC_COOLER) ? SRC_FD : p + 3'd1;
  endfunction

endpackage

// File: rtl/home_event_scheduler_if.sv
// Actuator request/acknowledge channel between the scheduler and the
// siren/notifier driver.
interface home_event_scheduler_if;
  import home_auto_pkg::*;

  logic       act_req;
  logic [2:0] act_code;
  logic       act_ack;

  // Scheduler side: raises the request and code, receives the ack
  modport master (
    output act_req,
    output act_code,
    input  act_ack
  );

  // Actuator side: observes the request and code, returns the ack
  modport slave (
    input  act_req,
    input  act_code,
    output act_ack
  );

endinterface

// File: rtl/rr_arbiter6.sv
// Six-way round-robin priority search. Starting one past the last served
// index, the first requesting source found wins. Purely combinational; the
// last-served pointer is owned by the caller.
module rr_arbiter6
  import home_auto_pkg::*;
(
  input  logic [5:0] req,
  input  logic [2:0] last,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Walk the rotation once, keeping the first hit
  always_comb begin
    valid = 1'b0;
    idx   = SRC_FD;
    cand  = rr_next(last);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/home_event_scheduler.sv
// Home event scheduler: latches door/fire/window/temperature events as
// sticky pending requests and serves them one at a time on a shared
// actuator channel, round-robin, with a req/ack handshake, a bounded ack
// wait and a minimum dwell of the one-hot output after acceptance.
module home_event_scheduler
  import home_auto_pkg::*;
#(
  parameter int LOW_T   = DEF_LOW_T,
  parameter int HIGH_T  = DEF_HIGH_T,
  parameter int DWELL   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             sensors,
  input  logic [5:0]             temp,
  home_event_scheduler_if.master act,
  output logic [5:0]             output_signals,
  output logic [2:0]             display,
  output logic [5:0]             pending,
  output logic                   timeout_err
);

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DWELL - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  sched_state_t      state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_q, last_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic [5:0] ev;
  logic [5:0] clr;
  logic [5:0] pending_d;
  logic       arb_valid;
  logic [2:0] arb_idx;

  logic       req_d;
  logic [2:0] code_d;
  logic [5:0] outs_d;
  logic [2:0] disp_d;
  logic       tmo_d;

  // Raw event vector: four level sensors plus the two temperature bands
  always_comb begin
    ev                   = '0;
    ev[SRC_W:SRC_FD]     = sensors;
    ev[SRC_HEATER]       = (int'(temp) < LOW_T);
    ev[SRC_COOLER]       = (int'(temp) > HIGH_T);
  end

  rr_arbiter6 u_arb (
    .req   (pending),
    .last  (last_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Next state, counters, pointer, pending update and next output values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    clr     = '0;
    tmo_d   = 1'b0;
    req_d   = 1'b0;
    code_d  = DISP_IDLE;
    outs_d  = '0;
    disp_d  = DISP_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_REQ;
          idx_d   = arb_idx;
          tcnt_d  = '0;
        end
      end
      ST_REQ: begin
        if (act.act_ack) begin
          state_d = ST_DWELL;
          dcnt_d  = DCNT_LOAD;
        end else if (tcnt_q == TCNT_LAST) begin
          // Give up on this source for now; its pending bit stays set so it
          // is retried once the rotation comes back around.
          tmo_d   = 1'b1;
          last_d  = idx_q;
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_DWELL: begin
        if (dcnt_q == '0) begin
          clr     = src_onehot(idx_q);
          last_d  = idx_q;
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered
    case (state_d)
      ST_REQ: begin
        req_d  = 1'b1;
        code_d = disp_code(idx_d);
        disp_d = disp_code(idx_d);
      end
      ST_DWELL: begin
        outs_d = src_onehot(idx_d);
        disp_d = disp_code(idx_d);
      end
      default: begin
        req_d = 1'b0;
      end
    endcase

    // A condition still present re-arms its bit in the same cycle it is served
    pending_d = (pending & ~clr) | ev;
  end

  // FSM state, latched winner, round-robin pointer, counters and pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= SRC_FD;
      last_q  <= SRC_COOLER;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      dcnt_q  <= dcnt_d;
      tcnt_q  <= tcnt_d;
      pending <= pending_d;
    end
  end

  // Registered actuator, display and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act.act_req    <= 1'b0;
      act.act_code   <= DISP_IDLE;
      output_signals <= '0;
      display        <= DISP_IDLE;
      timeout_err    <= 1'b0;
    end else begin
      act.act_req    <= req_d;
      act.act_code   <= code_d;
      output_signals <= outs_d;
      display        <= disp_d;
      timeout_err    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_home_event_scheduler.sv
// Testbench for home_event_scheduler: table-driven single-event vectors,
// a grant scoreboard fed by the stimulus and drained by an output monitor,
// and hand-written sequences for rotation, timeout and reset corner cases.
module tb_home_event_scheduler;

  localparam int DWELL_C   = 8;
  localparam int TIMEOUT_C = 32;

  logic       clk;
  logic       rst;
  logic [3:0] sensors;
  logic [5:0] temp;
  logic [5:0] output_signals;
  logic [2:0] display;
  logic [5:0] pending;
  logic       timeout_err;

  home_event_scheduler_if hif ();

  home_event_scheduler #(
    .LOW_T   (10),
    .HIGH_T  (21),
    .DWELL   (DWELL_C),
    .TIMEOUT (TIMEOUT_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sensors        (sensors),
    .temp           (temp),
    .act            (hif),
    .output_signals (output_signals),
    .display        (display),
    .pending        (pending),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];

  // Actuator model controls
  logic ack_en    = 1'b1;
  int   ack_delay = 1;
  int   req_cnt   = 0;

  // Monitor state
  logic       mon_prev_req = 1'b0;
  logic [5:0] mon_prev_out = '0;
  int         mon_code     = 0;
  int         mon_dlen     = 0;
  int         tmo_count    = 0;

  typedef struct {
    logic [3:0] sens;
    logic [5:0] tmp;
    logic [5:0] exp_pend;
    int         exp_code;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Wait until the scoreboard is drained and the DUT rests with nothing pending
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sb.size() == 0 && hif.act_req == 1'b0 &&
                 output_signals == 6'd0 && pending == 6'd0) && n < 600);
    if (n >= 600) begin
      fail(name);
      sb.delete();
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (hif.act_req !== 1'b1 && n < 100);
    if (n >= 100) fail(name);
  endtask

  // Actuator model: one-cycle ack a configurable number of cycles after req
  initial begin
    hif.act_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hif.act_req === 1'b1) req_cnt++;
      else req_cnt = 0;
      hif.act_ack = ack_en && (hif.act_req === 1'b1) && (req_cnt == ack_delay);
    end
  end

  // Output monitor: pops expected grant codes, checks dwell shape and length
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mon_prev_req = 1'b0;
        mon_prev_out = '0;
        mon_dlen     = 0;
      end else begin
        if (hif.act_req === 1'b1 && !mon_prev_req) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected grant: actual=%0d required=none", hif.act_code);
            mon_code = int'(hif.act_code);
          end else begin
            mon_code = sb.pop_front();
            check("grant code", 32'(hif.act_code), 32'(mon_code));
            check("req display", 32'(display), 32'(mon_code));
          end
        end
        if (output_signals != 6'd0) begin
          if (mon_prev_out == 6'd0 && mon_code >= 1 && mon_code <= 6) begin
            check("dwell onehot", 32'(output_signals), 32'(1) << (mon_code - 1));
            check("dwell display", 32'(display), 32'(mon_code));
          end
          mon_dlen++;
        end else if (mon_prev_out != 6'd0) begin
          check("dwell length", 32'(mon_dlen), 32'(DWELL_C));
          mon_dlen = 0;
        end
        if (timeout_err === 1'b1) tmo_count++;
        mon_prev_req = hif.act_req;
        mon_prev_out = output_signals;
      end
    end
  end

  // Hard stop if something hangs outside the bounded waits
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;

    vecs[0] = '{4'b0001, 6'd15, 6'b000001, 1};
    vecs[1] = '{4'b0010, 6'd15, 6'b000010, 2};
    vecs[2] = '{4'b0100, 6'd15, 6'b000100, 3};
    vecs[3] = '{4'b1000, 6'd15, 6'b001000, 4};
    vecs[4] = '{4'b0000, 6'd10, 6'b000000, 0};
    vecs[5] = '{4'b0000, 6'd21, 6'b000000, 0};
    vecs[6] = '{4'b0000, 6'd9,  6'b010000, 5};
    vecs[7] = '{4'b0000, 6'd22, 6'b100000, 6};

    rst     = 1'b1;
    sensors = 4'b0000;
    temp    = 6'd15;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset act_req", 32'(hif.act_req), 0);
    check("reset act_code", 32'(hif.act_code), 0);
    check("reset output_signals", 32'(output_signals), 0);
    check("reset display", 32'(display), 0);
    check("reset pending", 32'(pending), 0);
    check("reset timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-event vectors, ack two cycles after request
    ack_delay = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sensors = vecs[i].sens;
      temp    = vecs[i].tmp;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      if (vecs[i].exp_code != 0) sb.push_back(vecs[i].exp_code);
      @(negedge clk);
      sensors = 4'b0000;
      temp    = 6'd15;
      wait_idle($sformatf("vec%0d drain", i));
    end

    // All four sensors held: strict rotation FD, RD, FA, W, FD, RD ...
    ack_delay = 1;
    @(negedge clk);
    sensors = 4'b1111;
    temp    = 6'd15;
    sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4);
    sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4);
    sb.push_back(1);
    n = 0;
    while (sb.size() > 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("hold rotation");
    sensors = 4'b0000;
    wait_idle("hold rotation drain");

    // After FD (last=0), heater and FD together: heater is served first
    @(negedge clk);
    sensors = 4'b0001;
    sb.push_back(1);
    @(negedge clk);
    sensors = 4'b0000;
    wait_idle("fd serve");
    @(negedge clk);
    sensors = 4'b0001;
    temp    = 6'd5;
    @(posedge clk);
    #1;
    check("heater+fd pending", 32'(pending), 32'(6'b010001));
    sb.push_back(5);
    sb.push_back(1);
    @(negedge clk);
    sensors = 4'b0000;
    temp    = 6'd15;
    wait_idle("heater before fd");

    // No ack: RD times out, FA is granted next, RD is retried afterwards
    ack_en = 1'b0;
    @(negedge clk);
    sensors = 4'b0110;
    sb.push_back(2);
    @(negedge clk);
    sensors = 4'b0000;
    wait_req("timeout req rise");
    cnt = 0;
    while (hif.act_req === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("req high cycles", 32'(cnt), 32'(TIMEOUT_C));
    check("timeout pulse", 32'(timeout_err), 1);
    check("pending kept", 32'(pending), 32'(6'b000110));
    ack_en    = 1'b1;
    ack_delay = 1;
    sb.push_back(3);
    sb.push_back(2);
    @(posedge clk);
    #1;
    check("timeout one cycle", 32'(timeout_err), 0);
    wait_idle("timeout retry");

    // Reset in the middle of a dwell
    @(negedge clk);
    sensors = 4'b0001;
    sb.push_back(1);
    @(negedge clk);
    sensors = 4'b0000;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (output_signals == 6'd0 && n < 100);
    if (n >= 100) fail("dwell start");
    #2;
    rst = 1'b1;
    #1;
    check("rst dwell output_signals", 32'(output_signals), 0);
    check("rst dwell display", 32'(display), 0);
    check("rst dwell pending", 32'(pending), 0);
    check("rst dwell act_req", 32'(hif.act_req), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a request; RD is the lowest pending index
    ack_en = 1'b0;
    @(negedge clk);
    sensors = 4'b1110;
    temp    = 6'd5;
    sb.push_back(2);
    @(negedge clk);
    sensors = 4'b0000;
    temp    = 6'd15;
    wait_req("mid req rise");
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst req act_req", 32'(hif.act_req), 0);
    check("rst req act_code", 32'(hif.act_code), 0);
    check("rst req display", 32'(display), 0);
    check("rst req pending", 32'(pending), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    ack_en = 1'b1;

    // After reset the search starts at FD, so FA goes first here
    @(negedge clk);
    sensors = 4'b1100;
    temp    = 6'd22;
    sb.push_back(3);
    sb.push_back(4);
    sb.push_back(6);
    @(negedge clk);
    sensors = 4'b0000;
    temp    = 6'd15;
    wait_idle("post reset order");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard empty", 32'(sb.size()), 0);
    check("timeout pulse total", 32'(tmo_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
